// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and alu_share_arbiter.
//   req_valid/req_ready : per-requester request handshake (ready is one-hot or zero)
//   req_a/req_b/req_op  : packed operands and op code, requester i at [32*i +: 32] / [4*i +: 4]
//   rsp_valid/rsp_ready : per-requester response handshake (valid is one-hot or zero)
//   rsp_result/rsp_id   : registered result and the index of the requester that owns it
// The arbiter connects through the slave modport; requesters use master.
interface alu_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*4-1:0]  req_op;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [31:0]           rsp_result;
  logic [ID_W-1:0]       rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_id
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational 32-bit ALU between NUM_REQ requesters.
// One transaction in flight: IDLE (grant/accept) -> EXEC (ALU evaluates) -> RESP (hold result).
// Ports:
//   clk, rst          : clock and asynchronous active-high reset
//   bus (slave)       : request/response handshakes, operands, result and owner id
//   alu_in_a_o/b_o    : registered operands to the external ALU
//   alu_select_o      : registered op code to the external ALU (passed through unchecked)
//   alu_result_i      : combinational ALU result, captured at the end of EXEC
//   busy_o            : high whenever a transaction is in flight
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  alu_share_arbiter_if.slave        bus,
  output logic [31:0]               alu_in_a_o,
  output logic [31:0]               alu_in_b_o,
  output logic [3:0]                alu_select_o,
  input  logic [31:0]               alu_result_i,
  output logic                      busy_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [3:0]      op_q, op_d;
  logic [31:0]     result_q, result_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;

  // First valid requester at or above rr_ptr, wrapping NUM_REQ-1 -> 0.
  always_comb begin
    logic [ID_W-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    rsp_id_d        = rsp_id_q;
    a_d             = a_q;
    b_d             = b_q;
    op_d            = op_q;
    result_d        = result_q;
    bus.req_ready   = '0;
    bus.rsp_valid   = '0;

    unique case (state_q)
      StIdle: begin
        // Gate with rst so ready stays low while reset is asserted.
        if (grant_found && !rst) begin
          bus.req_ready[grant_idx] = 1'b1;
          a_d      = bus.req_a[32*grant_idx +: 32];
          b_d      = bus.req_b[32*grant_idx +: 32];
          op_d     = bus.req_op[4*grant_idx +: 4];
          rsp_id_d = grant_idx;
          state_d  = StExec;
        end
      end
      StExec: begin
        result_d = alu_result_i;
        state_d  = StResp;
      end
      StResp: begin
        bus.rsp_valid[rsp_id_q] = 1'b1;
        if (bus.rsp_ready[rsp_id_q]) begin
          state_d = StIdle;
          if (32'(rsp_id_q) == NUM_REQ - 1) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = rsp_id_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      rsp_id_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      rsp_id_q <= rsp_id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign alu_in_a_o     = a_q;
  assign alu_in_b_o     = b_q;
  assign alu_select_o   = op_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_id     = rsp_id_q;
  assign busy_o         = (state_q != StIdle);

endmodule
